// File: rtl/video_avm_cfg_master.sv
// Queues register-write commands and replays them as Avalon-MM writes,
// optionally holding them back until the video timing is in blanking.
module video_avm_cfg_master #(
    parameter int ADDR_SIZE  = 1,
    parameter int DATA_SIZE  = 32,
    parameter int DEPTH      = 4,
    parameter int SYNC_BLANK = 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     cmd_vld,
    output logic                     cmd_rdy,
    input  logic [ADDR_SIZE-1:0]     cmd_address,
    input  logic [DATA_SIZE-1:0]     cmd_writedata,
    input  logic                     frame_display,
    output logic [ADDR_SIZE-1:0]     avm_address,
    output logic                     avm_write,
    output logic [DATA_SIZE-1:0]     avm_writedata,
    input  logic                     avm_waitrequest,
    output logic [$clog2(DEPTH):0]   cmd_count,
    output logic                     busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t state;

    logic [ADDR_SIZE-1:0] addr_mem [DEPTH];
    logic [DATA_SIZE-1:0] data_mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        rd_next;

    logic push;
    logic pop;
    logic permit;
    logic more;

    assign cmd_rdy = (cmd_count < DEPTH_C);
    assign push    = cmd_vld && cmd_rdy && !sys_rst;
    assign pop     = (state == WRITE) && !avm_waitrequest;
    assign permit  = (SYNC_BLANK == 0) || !frame_display;
    // The in-flight write is still counted, so a follow-on entry exists only
    // if more than one was present before this cycle's pop.
    assign more    = (cmd_count > CW'(1));
    assign rd_next = rd_ptr + PW'(1);
    assign busy    = (cmd_count != '0) || avm_write;

    // Command storage; contents need no reset since pointers gate validity.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= cmd_address;
            data_mem[wr_ptr] <= cmd_writedata;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmd_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_next;
            case ({push, pop})
                2'b10:   cmd_count <= cmd_count + CW'(1);
                2'b01:   cmd_count <= cmd_count - CW'(1);
                default: cmd_count <= cmd_count;
            endcase
        end
    end

    // Write-issue FSM with registered Avalon outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= IDLE;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((cmd_count != '0) && permit) begin
                        avm_address   <= addr_mem[rd_ptr];
                        avm_writedata <= data_mem[rd_ptr];
                        avm_write     <= 1'b1;
                        state         <= WRITE;
                    end
                end
                WRITE: begin
                    if (!avm_waitrequest) begin
                        if (more && permit) begin
                            avm_address   <= addr_mem[rd_next];
                            avm_writedata <= data_mem[rd_next];
                        end else begin
                            avm_write <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    avm_write <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_avm_cfg_master.sv
// Directed bench for video_avm_cfg_master: blanking gate, full FIFO,
// waitrequest stall, streaming across pointer wrap, reset mid-burst.
module tb_video_avm_cfg_master;

    logic        clk;
    logic        sys_rst;
    logic        cmd_vld;
    logic [0:0]  cmd_address;
    logic [31:0] cmd_writedata;
    logic        frame_display;
    logic        avm_waitrequest;

    logic        cmd_rdy;
    logic [0:0]  avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [2:0]  cmd_count;
    logic        busy;

    logic        n_cmd_rdy;
    logic [0:0]  n_avm_address;
    logic        n_avm_write;
    logic [31:0] n_avm_writedata;
    logic [2:0]  n_cmd_count;
    logic        n_busy;

    int tests;
    int failed;

    video_avm_cfg_master #(
        .ADDR_SIZE(1), .DATA_SIZE(32), .DEPTH(4), .SYNC_BLANK(1)
    ) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
        .frame_display(frame_display), .avm_address(avm_address),
        .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest), .cmd_count(cmd_count), .busy(busy)
    );

    video_avm_cfg_master #(
        .ADDR_SIZE(1), .DATA_SIZE(32), .DEPTH(4), .SYNC_BLANK(0)
    ) dut_nb (
        .sys_clk(clk), .sys_rst(sys_rst), .cmd_vld(cmd_vld), .cmd_rdy(n_cmd_rdy),
        .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
        .frame_display(frame_display), .avm_address(n_avm_address),
        .avm_write(n_avm_write), .avm_writedata(n_avm_writedata),
        .avm_waitrequest(avm_waitrequest), .cmd_count(n_cmd_count), .busy(n_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        int nexp;
        int gaps;
        bit started;
        logic [31:0] d;

        tests = 0;
        failed = 0;
        sys_rst = 1'b1;
        cmd_vld = 1'b0;
        cmd_address = '0;
        cmd_writedata = '0;
        frame_display = 1'b0;
        avm_waitrequest = 1'b0;

        // Reset / idle
        tick(); tick();
        sys_rst = 1'b0;
        tick();
        check("rst_rdy", cmd_rdy, 1);
        check("rst_count", cmd_count, 0);
        check("rst_write", avm_write, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", avm_address, 0);
        check("rst_data", avm_writedata, 0);

        // Blanking gate
        frame_display = 1'b1;
        cmd_vld = 1'b1; cmd_address = 1'b1; cmd_writedata = 32'h0000_0ABC;
        tick();
        cmd_vld = 1'b0;
        check("gate_count1", cmd_count, 1);
        check("gate_nowrite1", avm_write, 0);
        check("gate_busy", busy, 1);
        tick();
        check("nb_write", n_avm_write, 1);
        check("nb_data", n_avm_writedata, 32'h0000_0ABC);
        for (int k = 0; k < 3; k++) begin
            check("gate_nowrite", avm_write, 0);
            check("gate_hold_count", cmd_count, 1);
            tick();
        end
        frame_display = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) begin
                check("gate_wr_now", avm_write, 1);
                check("gate_addr", avm_address, 1);
                check("gate_data", avm_writedata, 32'h0000_0ABC);
            end
            if (avm_write) pulses++;
        end
        check("gate_pulses", pulses, 1);
        check("gate_count0", cmd_count, 0);
        check("gate_hold_data", avm_writedata, 32'h0000_0ABC);

        // Back-to-back and full
        frame_display = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_vld = 1'b1; cmd_address = 1'(i); cmd_writedata = 32'h100 + 32'(i);
            tick();
        end
        check("full_count", cmd_count, 4);
        check("full_rdy", cmd_rdy, 0);
        cmd_writedata = 32'hDEAD;
        tick();
        cmd_vld = 1'b0;
        check("full_reject", cmd_count, 4);
        frame_display = 1'b0;
        tick();
        check("b2b_w0", avm_write, 1);
        check("b2b_d0", avm_writedata, 32'h100);
        check("b2b_rdy0", cmd_rdy, 0);
        tick();
        check("b2b_d1", avm_writedata, 32'h101);
        check("b2b_a1", avm_address, 1);
        check("b2b_rdy1", cmd_rdy, 1);
        check("b2b_c1", cmd_count, 3);
        tick();
        check("b2b_d2", avm_writedata, 32'h102);
        check("b2b_w2", avm_write, 1);
        tick();
        check("b2b_d3", avm_writedata, 32'h103);
        check("b2b_c3", cmd_count, 1);
        tick();
        check("b2b_end", avm_write, 0);
        check("b2b_empty", cmd_count, 0);

        // Waitrequest stall, frame_display rising mid-stall
        avm_waitrequest = 1'b1;
        cmd_vld = 1'b1; cmd_address = 1'b1; cmd_writedata = 32'h55AA;
        tick();
        cmd_vld = 1'b0;
        tick();
        check("wr_start", avm_write, 1);
        frame_display = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("wr_hold_w", avm_write, 1);
            check("wr_hold_d", avm_writedata, 32'h55AA);
            check("wr_hold_a", avm_address, 1);
            check("wr_hold_c", cmd_count, 1);
        end
        avm_waitrequest = 1'b0;
        tick();
        check("wr_done", avm_write, 0);
        check("wr_popped", cmd_count, 0);
        frame_display = 1'b0;
        tick();

        // Streaming concurrent push/pop across pointer wrap
        nexp = 0; gaps = 0; started = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cmd_vld = 1'b1; cmd_address = 1'(i); cmd_writedata = 32'h200 + 32'(i);
            tick();
            if (i == 10) check("stream_count", cmd_count, 2);
            if (avm_write) begin
                started = 1'b1;
                d = 32'h200 + 32'(nexp);
                check("stream_data", avm_writedata, d);
                nexp++;
            end else if (started) begin
                gaps++;
            end
        end
        cmd_vld = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (avm_write) begin
                d = 32'h200 + 32'(nexp);
                check("stream_data", avm_writedata, d);
                nexp++;
            end else if (nexp < 20) begin
                gaps++;
            end
        end
        check("stream_total", nexp, 20);
        check("stream_gaps", gaps, 0);

        // Reset mid-burst
        frame_display = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_vld = 1'b1; cmd_address = 1'(i); cmd_writedata = 32'h300 + 32'(i);
            tick();
        end
        cmd_vld = 1'b0;
        frame_display = 1'b0;
        tick();
        tick();
        check("rb_write", avm_write, 1);
        check("rb_count", cmd_count, 3);
        check("rb_data", avm_writedata, 32'h301);
        sys_rst = 1'b1;
        cmd_vld = 1'b1; cmd_writedata = 32'hBAD;
        tick();
        sys_rst = 1'b0;
        cmd_vld = 1'b0;
        check("rb_drop", avm_write, 0);
        check("rb_cleared", cmd_count, 0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (avm_write) pulses++;
        end
        check("rb_no_issue", pulses, 0);
        check("rb_rdy", cmd_rdy, 1);
        check("rb_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
